// File: rtl/viterbi_pkg.sv
// Shared types for the Viterbi frame sequencer.
// Frame FSM states and the 2-bit channel symbol.
package viterbi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DATA,
    TAIL,
    FLUSH,
    DRAIN,
    DONE
  } frame_state_t;

  typedef logic [1:0] sym_t;

  localparam sym_t SYM_ZERO = 2'b00;

endpackage

// File: rtl/viterbi_drain_timer.sv
// Counts consecutive core-idle cycles while draining.
// Expires on the cycle the count would reach DRAIN_CYC.
module viterbi_drain_timer #(
  parameter int DRAIN_CYC = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(DRAIN_CYC + 1);
  localparam logic [CW-1:0] TOP  = CW'(DRAIN_CYC);
  localparam logic [CW-1:0] LAST = CW'(DRAIN_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || restart) begin
      cnt <= '0;
    end else if (cnt != TOP) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && !restart && (cnt == LAST);

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer feeding tt_um_viterbi_core: data, tail, flush, drain.
// Optional VITERBI_FRAME_STATS_EN adds frame/error statistics ports.
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int K         = 3,
  parameter int LEN_W     = 8,
  parameter int FLUSH_MAX = 64,
  parameter int DRAIN_CYC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             s_sym_valid,
  output logic             s_sym_ready,
  input  sym_t             s_sym,
  output logic             core_sym_valid,
  input  logic             core_sym_ready,
  output sym_t             core_sym,
  output logic             core_force_state0,
  input  logic             core_bit_valid,
  input  logic             core_bit,
  output logic             m_bit_valid,
  output logic             m_bit,
  output logic             m_bit_last
`ifdef VITERBI_FRAME_STATS_EN
  ,
  output logic [15:0]      stat_frames,
  output logic [15:0]      stat_errs
`endif
);

  localparam int M  = K - 1;
  localparam int FW = $clog2(FLUSH_MAX + 1);
  localparam logic [LEN_W-1:0] M_LAST = LEN_W'(M - 1);
  localparam logic [FW-1:0]    F_LAST = FW'(FLUSH_MAX - 1);

  frame_state_t     state;
  logic [LEN_W-1:0] n_len;
  logic [LEN_W-1:0] sym_cnt;
  logic [LEN_W-1:0] out_cnt;
  logic [FW-1:0]    flush_cnt;
  logic             err_flag;
  logic             hold;
  logic             xfer;
  logic             out_full;
  logic             bit_ok;
  logic             drain_exp;

  assign out_full = (out_cnt == n_len);
  assign xfer     = core_sym_valid && core_sym_ready;
  assign bit_ok   = core_bit_valid && !out_full &&
                    (state inside {DATA, TAIL, FLUSH});

  // A stalled flush symbol stays offered even once the bit quota is met.
  always_comb begin
    s_sym_ready    = 1'b0;
    core_sym_valid = 1'b0;
    core_sym       = SYM_ZERO;
    unique case (state)
      DATA: begin
        core_sym_valid = s_sym_valid;
        core_sym       = s_sym;
        s_sym_ready    = core_sym_ready;
      end
      TAIL:    core_sym_valid = 1'b1;
      FLUSH:   core_sym_valid = hold || !out_full;
      default: ;
    endcase
  end

  viterbi_drain_timer #(
    .DRAIN_CYC(DRAIN_CYC)
  ) u_drain (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(core_bit_valid),
    .en     (state == DRAIN),
    .expired(drain_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      n_len             <= '0;
      sym_cnt           <= '0;
      out_cnt           <= '0;
      flush_cnt         <= '0;
      err_flag          <= 1'b0;
      hold              <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      core_force_state0 <= 1'b0;
      m_bit_valid       <= 1'b0;
      m_bit             <= 1'b0;
      m_bit_last        <= 1'b0;
    end else begin
      done              <= 1'b0;
      err               <= 1'b0;
      core_force_state0 <= 1'b0;
      m_bit_valid       <= bit_ok;
      m_bit             <= bit_ok && core_bit;
      m_bit_last        <= bit_ok && (out_cnt == n_len - 1'b1);
      hold              <= core_sym_valid && !core_sym_ready;
      if (bit_ok) out_cnt <= out_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (cfg_start) begin
            n_len     <= cfg_len;
            sym_cnt   <= '0;
            out_cnt   <= '0;
            flush_cnt <= '0;
            busy      <= 1'b1;
            if (cfg_len == '0) begin
              err_flag <= 1'b1;
              done     <= 1'b1;
              err      <= 1'b1;
              state    <= DONE;
            end else begin
              err_flag          <= 1'b0;
              core_force_state0 <= 1'b1;
              state             <= LOAD;
            end
          end
        end
        LOAD: state <= DATA;
        DATA: begin
          if (xfer) begin
            if (sym_cnt == n_len - 1'b1) begin
              sym_cnt <= '0;
              state   <= TAIL;
            end else begin
              sym_cnt <= sym_cnt + 1'b1;
            end
          end
        end
        TAIL: begin
          if (xfer) begin
            if (sym_cnt == M_LAST) begin
              sym_cnt <= '0;
              state   <= FLUSH;
            end else begin
              sym_cnt <= sym_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (xfer) flush_cnt <= flush_cnt + 1'b1;
          if (xfer && flush_cnt == F_LAST) begin
            err_flag <= 1'b1;
            state    <= DRAIN;
          end else if (out_full && (xfer || !hold)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_exp) begin
            done  <= 1'b1;
            err   <= err_flag;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VITERBI_FRAME_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_errs   <= '0;
    end else if (done) begin
      if (stat_frames != 16'hFFFF) stat_frames <= stat_frames + 1'b1;
      if (err && stat_errs != 16'hFFFF) stat_errs <= stat_errs + 1'b1;
    end
  end
`endif

endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Frame sequencer in front of `tt_um_viterbi_core`. It takes a configured frame length N and forwards N upstream data symbols into the core. It then appends K-1 zero tail symbols and feeds zero flush symbols until N decoded bits have emerged. Finally it drains and discards the core's residual outputs before signalling frame completion, so the system sees exactly N bits per frame with a `last` flag.

## Interface
- `K`, 3, constraint length; M = K-1 tail symbols.
- `LEN_W`, 8, width of the frame-length field.
- `FLUSH_MAX`, 64, maximum flush symbols before timeout.
- `DRAIN_CYC`, 8, consecutive core-idle cycles that end the drain.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `cfg_start` in 1: one-cycle frame start request.
- `cfg_len` in LEN_W: N, the number of info bits/symbols in the frame.
- `busy` out 1: high from start acceptance until DONE.
- `done` out 1: one-cycle frame-complete pulse.
- `err` out 1: one-cycle pulse on timeout or N=0, coincident with `done`.
- `s_sym_valid` in 1, `s_sym_ready` out 1, `s_sym` in 2: upstream symbol stream, {y0,y1}.
- `core_sym_valid` out 1, `core_sym_ready` in 1, `core_sym` out 2: drive the core's rx_sym port.
- `core_force_state0` out 1: core path-metric re-initialisation.
- `core_bit_valid` in 1, `core_bit` in 1: core decoded output. The core has no backpressure on this port.
- `m_bit_valid` out 1, `m_bit` out 1, `m_bit_last` out 1: decoded frame bits. Downstream cannot stall.

## Operation
- States: IDLE → LOAD → DATA → TAIL → FLUSH → DRAIN → DONE → IDLE.
- IDLE:
  - `cfg_start`=1 with `cfg_len`≠0 latches N and clears all counters, then goes to LOAD.
  - `cfg_len`=0 goes directly to DONE with `err`.
  - `cfg_start` is ignored in every other state.
- LOAD:
  - Lasts one cycle with `core_force_state0`=1.
  - No symbol is offered.
  - Next state is DATA.
- DATA:
  - `core_sym_valid`=`s_sym_valid`, `core_sym`=`s_sym`, `s_sym_ready`=`core_sym_ready`.
  - Outside DATA, `s_sym_ready`=0.
  - After the Nth accepted symbol, go to TAIL.
- TAIL:
  - `core_sym_valid`=1, `core_sym`=2'b00.
  - After M accepted symbols, go to FLUSH.
- FLUSH:
  - Offers 2'b00 symbols as in TAIL, counting accepted flush symbols.
  - Goes to DRAIN when the output count reaches N.
  - Also goes to DRAIN if the flush count reaches FLUSH_MAX, which sets an error flag.
- Output counting in DATA, TAIL and FLUSH:
  - Every `core_bit_valid` with out_cnt<N is forwarded and increments out_cnt.
  - `m_bit_last`=1 on out_cnt==N-1.
  - If out_cnt reaches N while still in DATA or TAIL, the state still completes its symbol quota, then FLUSH exits immediately with zero flush symbols.
- DRAIN:
  - No symbols are offered; core bits are discarded.
  - An idle counter resets on every `core_bit_valid`.
  - When the idle counter reaches DRAIN_CYC, go to DONE.
- DONE:
  - One cycle: `done`=1, plus `err`=1 if the flag is set.
  - Next state is IDLE with `busy`=0.
- Counter widths:
  - data/out counters: LEN_W.
  - flush counter: $clog2(FLUSH_MAX+1).
  - idle counter: $clog2(DRAIN_CYC+1).
  - No wrap: each counter compares against its terminal value before incrementing.
- Reset (asynchronous, at any time including mid-frame):
  - State goes to IDLE and counters clear.
  - All outputs are 0; `core_sym` is 2'b00.
  - A partial frame is abandoned; no `done` is issued.

## Timing
- `cfg_start` accepted at edge t:
  - `busy`=1 and LOAD from t+1.
  - DATA from t+2; the first symbol can transfer at edge t+2.
- Symbol transfer occurs on any edge with valid&&ready.
- `core_sym_valid` and `core_sym` are registered-stable while valid && !ready: no retraction, no change.
- `m_bit_valid`, `m_bit` and `m_bit_last` are registered, one cycle after `core_bit_valid`.
- A `core_bit_valid` in the same cycle as the DATA→TAIL or TAIL→FLUSH transition is still forwarded.
- A bit that arrives after the transition into DRAIN is discarded.
- `done` rises DRAIN_CYC+1 cycles after the last core bit at the earliest.

## Configuration
- `VITERBI_FRAME_STATS_EN` defined:
  - Adds output ports `stat_frames[15:0]` (frames completed) and `stat_errs[15:0]` (`err` pulses).
  - Both increment on the DONE cycle and saturate at 16'hFFFF.
  - Both reset to 0.
- Not defined: the ports and counters are absent.
- Control behaviour is identical in both cases.

## Structure
- Shared package `viterbi_pkg`:
  - `frame_state_t` enum (IDLE, LOAD, DATA, TAIL, FLUSH, DRAIN, DONE).
  - Symbol typedef `sym_t` (logic [1:0]).
  - Constant `SYM_ZERO`.
- One sub-module, `viterbi_drain_timer`:
  - Idle-cycle counter with restart input (`core_bit_valid`), enable input (state==DRAIN) and `expired` output.

## Test plan
- **Nominal frame.** K=3, D=6, N=16, bits 0xACF0 MSB-first, encoded with G=7,5 and fed with `s_sym_valid` continuous.
  - Exactly 16 `m_bit_valid` pulses, equal to 0xACF0 MSB-first.
  - `m_bit_last` on the 16th only.
  - Exactly 2 tail symbols of 00 sent.
  - `done`=1, `err`=0.
- **Backpressure.** Same frame with `core_sym_ready` toggling 1-of-3 cycles.
  - Identical output bits.
  - `core_sym` and `core_sym_valid` stable while stalled.
- **Timeout.** Core stub that never asserts `core_bit_valid`, FLUSH_MAX=32, N=4.
  - 4 data + 2 tail + 32 flush symbols.
  - Then `done` and `err` pulse together, with 0 output bits.
- **Zero length.** `cfg_start` with `cfg_len`=0.
  - `done` and `err` within 2 cycles.
  - No `core_sym_valid` and no `core_force_state0`.
- **Ignored start and mid-frame reset.**
  - `cfg_start` pulsed during DATA: no effect on N or the counters.
  - `rst_n` low at the 5th data symbol: all outputs 0 immediately.
  - After release, a new N=8 frame decodes correctly.
- **Drain.** Stub that emits 3 extra bits after the Nth bit.
  - Extra bits are not forwarded.
  - `done` occurs DRAIN_CYC+1 cycles after the last extra bit.
